// File: rtl/rom_word_loader.sv
// Boot-image streamer: reads an internal byte ROM sequentially, packs bytes
// little-endian into words and writes them out over a valid/ready port.
// The image is supplied through the INIT_IMAGE parameter (byte i at bits
// [8i+7:8i]) so the ROM is a pure constant table with no file loading.
module rom_word_loader #(
  parameter int unsigned               IMAGE_BYTES = 153,
  parameter int unsigned               WORD_BYTES  = 4,
  parameter int unsigned               ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR   = '0,
  parameter logic [8*IMAGE_BYTES-1:0]  INIT_IMAGE  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_data,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned NW = (IMAGE_BYTES + WORD_BYTES - 1) / WORD_BYTES;
  localparam int unsigned BW = $clog2(NW * WORD_BYTES + 1);
  localparam int unsigned RW = (IMAGE_BYTES > 1) ? $clog2(IMAGE_BYTES) : 1;
  localparam int unsigned LW = $clog2(WORD_BYTES + 1);
  localparam int unsigned WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned RD = 1 << RW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [WW-1:0]             word_q, word_d;
  logic [LW-1:0]             lane_q, lane_d;
  logic [BW-1:0]             base_q, base_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [8*WORD_BYTES-1:0]   pack_q, pack_d;
  logic [7:0]                rom_q, rom_d;
  logic                      rom_vld_q, rom_vld_d;
  logic [BW-1:0]             rd_idx;
  logic [7:0]                rom_w [RD];

  // ROM table padded to a power of two so every index is in range.
  for (genvar g = 0; g < RD; g++) begin : g_rom
    if (g < IMAGE_BYTES) begin : g_img
      assign rom_w[g] = INIT_IMAGE[8*g +: 8];
    end else begin : g_pad
      assign rom_w[g] = '0;
    end
  end

  assign rd_idx = base_q + BW'(lane_q);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      lane_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      pack_q    <= '0;
      rom_q     <= '0;
      rom_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      lane_q    <= lane_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      pack_q    <= pack_d;
      rom_q     <= rom_d;
      rom_vld_q <= rom_vld_d;
    end
  end

  // Next-state logic. In FETCH, lane_q issues a ROM read for lane lane_q and
  // captures the byte read in the previous cycle into lane lane_q-1.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    lane_d    = lane_q;
    base_d    = base_q;
    addr_d    = addr_q;
    pack_d    = pack_q;
    rom_d     = rom_q;
    rom_vld_d = rom_vld_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_FETCH;
          word_d    = '0;
          lane_d    = '0;
          base_d    = '0;
          addr_d    = BASE_ADDR;
          rom_vld_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (lane_q < LW'(WORD_BYTES)) begin
          if (rd_idx < BW'(IMAGE_BYTES)) begin
            rom_d     = rom_w[rd_idx[RW-1:0]];
            rom_vld_d = 1'b1;
          end else begin
            rom_vld_d = 1'b0;
          end
        end
        for (int unsigned l = 0; l < WORD_BYTES; l++) begin
          if (lane_q == LW'(l + 1)) begin
            pack_d[8*l +: 8] = rom_vld_q ? rom_q : '0;
          end
        end
        if (lane_q == LW'(WORD_BYTES)) begin
          state_d = S_EMIT;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (wr_ready) begin
          if (word_q == WW'(NW - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            word_d  = word_q + 1'b1;
            lane_d  = '0;
            base_d  = base_q + BW'(WORD_BYTES);
            addr_d  = addr_q + ADDR_WIDTH'(WORD_BYTES);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_valid = (state_q == S_EMIT);
  assign busy     = (state_q == S_FETCH) || (state_q == S_EMIT);
  assign done     = (state_q == S_DONE);
  assign wr_addr  = addr_q;
  assign wr_data  = pack_q;

endmodule

// File: tb/tb_rom_word_loader.sv
module tb_rom_word_loader;

  localparam int NB_A = 153;
  localparam int NW_A = 39;

  function automatic logic [7:0] img_byte(input int i);
    if (i == 0) return 8'h9D;
    if (i == 4) return 8'h77;
    if (i < 8) return 8'h00;
    return 8'(i * 37 + 5);
  endfunction

  function automatic logic [8*NB_A-1:0] make_img();
    logic [8*NB_A-1:0] v;
    v = '0;
    for (int i = NB_A - 1; i >= 0; i--) v = {v[8*(NB_A-1)-1:0], img_byte(i)};
    return v;
  endfunction

  localparam logic [8*NB_A-1:0] IMG_A = make_img();

  function automatic logic [31:0] exp_word_a(input int k);
    logic [31:0] w;
    w = '0;
    for (int l = 0; l < 4; l++) begin
      if (k * 4 + l < NB_A) w = w | (32'(img_byte(k * 4 + l)) << (8 * l));
    end
    return w;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          k;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  logic        clk;
  logic        rst_a_n, rst_b_n, start_a, start_b, ready_a, ready_b;
  logic        a_valid, a_busy, a_done, b_valid, b_busy, b_done;
  logic [31:0] a_addr, a_data, b_addr, b_data;

  int total, bad, cyc;
  int wcnt_a, wcnt_b;
  wr_t qa[$], qb[$];
  logic [31:0] wlog_addr_a [1024];
  logic [31:0] wlog_data_a [1024];
  int          wlog_cyc_a  [1024];

  rom_word_loader #(
    .IMAGE_BYTES(NB_A), .WORD_BYTES(4), .ADDR_WIDTH(32),
    .BASE_ADDR(32'h0), .INIT_IMAGE(IMG_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .wr_valid(a_valid),
    .wr_ready(ready_a), .wr_addr(a_addr), .wr_data(a_data),
    .busy(a_busy), .done(a_done)
  );

  rom_word_loader #(
    .IMAGE_BYTES(6), .WORD_BYTES(4), .ADDR_WIDTH(32),
    .BASE_ADDR(32'h0), .INIT_IMAGE(48'h665544332211)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .start(start_b), .wr_valid(b_valid),
    .wr_ready(ready_b), .wr_addr(b_addr), .wr_data(b_data),
    .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: actual=timeout required=event", nm);
  endtask

  // Scoreboard monitors: a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst_a_n && a_valid) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra_write: actual addr=%0h data=%0h required=none", a_addr, a_data);
      end else if (ready_a) begin
        wr_t e;
        e = qa.pop_front();
        check("a_addr", 64'(a_addr), 64'(e.addr));
        check("a_data", 64'(a_data), 64'(e.data));
        wlog_addr_a[wcnt_a % 1024] = a_addr;
        wlog_data_a[wcnt_a % 1024] = a_data;
        wlog_cyc_a[wcnt_a % 1024]  = cyc;
        wcnt_a++;
      end else begin
        check("a_stall_addr", 64'(a_addr), 64'(qa[0].addr));
        check("a_stall_data", 64'(a_data), 64'(qa[0].data));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b_n && b_valid && ready_b) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_extra_write: actual addr=%0h data=%0h required=none", b_addr, b_data);
      end else begin
        wr_t e;
        e = qb.pop_front();
        check("b_addr", 64'(b_addr), 64'(e.addr));
        check("b_data", 64'(b_data), 64'(e.data));
        wcnt_b++;
      end
    end
  end

  task automatic start_load_a();
    for (int k = 0; k < NW_A; k++) qa.push_back('{addr: 32'(k * 4), data: exp_word_a(k)});
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string nm);
    int n = 0;
    while (!a_done && n < 600) begin @(posedge clk); #1; n++; end
    if (!a_done) timeout(nm);
  endtask

  task automatic wait_valid_a(input string nm);
    int n = 0;
    while (!a_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!a_valid) timeout(nm);
  endtask

  task automatic wait_wcnt_a(input int target, input string nm);
    int n = 0;
    while (wcnt_a < target && n < 600) begin @(posedge clk); #1; n++; end
    if (wcnt_a < target) timeout(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   base, lat, n;
    vecs[0] = '{k: 0,  addr: 32'h0,  data: 32'h0000009D};
    vecs[1] = '{k: 1,  addr: 32'h4,  data: 32'h00000077};
    vecs[2] = '{k: 2,  addr: 32'h8,  data: 32'h9C77522D};
    vecs[3] = '{k: 38, addr: 32'h98, data: 32'h000000FD};

    clk = 0; cyc = 0; total = 0; bad = 0; wcnt_a = 0; wcnt_b = 0;
    rst_a_n = 0; rst_b_n = 0; start_a = 0; start_b = 0; ready_a = 1; ready_b = 1;
    #12;
    check("rst_a_flags", 64'({a_valid, a_busy, a_done}), 64'(0));
    check("rst_a_addr_data", {a_addr, a_data}, 64'(0));
    check("rst_b_flags", 64'({b_valid, b_busy, b_done}), 64'(0));
    @(posedge clk); #1;
    rst_a_n = 1; rst_b_n = 1;
    @(posedge clk); #1;

    // Full load with wr_ready held high.
    base = wcnt_a;
    start_load_a();
    lat = 1;
    while (!a_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("first_valid_latency", 64'(lat), 64'(6));
    wait_done_a("full_done");
    check("full_count", 64'(wcnt_a - base), 64'(NW_A));
    check("full_queue_empty", 64'(qa.size()), 64'(0));
    check("full_done_flags", 64'({a_done, a_busy, a_valid}), 64'(3'b100));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("vec_addr_k%0d", vecs[i].k), 64'(wlog_addr_a[base + vecs[i].k]), 64'(vecs[i].addr));
      check($sformatf("vec_data_k%0d", vecs[i].k), 64'(wlog_data_a[base + vecs[i].k]), 64'(vecs[i].data));
    end
    check("throughput", 64'(wlog_cyc_a[base + 38] - wlog_cyc_a[base]), 64'(38 * 6));

    // start during EMIT is ignored.
    base = wcnt_a;
    ready_a = 0;
    start_load_a();
    wait_valid_a("ign_valid");
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    check("ign_still_emit", 64'({a_valid, a_busy, a_done}), 64'(3'b110));
    ready_a = 1;
    wait_done_a("ign_done");
    check("ign_count", 64'(wcnt_a - base), 64'(NW_A));

    // Restart from DONE reissues the same sequence.
    base = wcnt_a;
    start_load_a();
    check("restart_flags", 64'({a_done, a_busy}), 64'(2'b01));
    wait_done_a("restart_done");
    check("restart_count", 64'(wcnt_a - base), 64'(NW_A));

    // Backpressure on word 2 for 5 cycles.
    base = wcnt_a;
    start_load_a();
    wait_wcnt_a(base + 2, "bp_two_words");
    ready_a = 0;
    wait_valid_a("bp_valid");
    repeat (5) begin @(posedge clk); #1; end
    check("bp_held", 64'({a_valid, a_addr}), {31'd0, 1'b1, 32'h8});
    check("bp_no_write", 64'(wcnt_a - base), 64'(2));
    ready_a = 1;
    wait_done_a("bp_done");
    check("bp_count", 64'(wcnt_a - base), 64'(NW_A));

    // Partial last word on the 6-byte image.
    qb.push_back('{addr: 32'h0, data: 32'h44332211});
    qb.push_back('{addr: 32'h4, data: 32'h00006655});
    start_b = 1;
    @(posedge clk); #1;
    start_b = 0;
    n = 0;
    while (!b_done && n < 100) begin @(posedge clk); #1; n++; end
    if (!b_done) timeout("b_done");
    check("b_count", 64'(wcnt_b), 64'(2));
    check("b_queue_empty", 64'(qb.size()), 64'(0));

    // Reset during word 10 FETCH aborts the load.
    base = wcnt_a;
    start_load_a();
    wait_wcnt_a(base + 10, "mid_ten_words");
    repeat (2) begin @(posedge clk); #1; end
    rst_a_n = 0;
    qa.delete();
    #1;
    check("mid_rst_flags", 64'({a_valid, a_busy, a_done}), 64'(0));
    base = wcnt_a;
    repeat (20) begin @(posedge clk); #1; end
    check("mid_no_writes", 64'(wcnt_a - base), 64'(0));
    rst_a_n = 1;
    @(posedge clk); #1;
    base = wcnt_a;
    start_load_a();
    wait_done_a("mid_reload_done");
    check("mid_reload_count", 64'(wcnt_a - base), 64'(NW_A));
    check("mid_reload_first_addr", 64'(wlog_addr_a[base]), 64'(0));

    // Asynchronous reset at a random point of a load.
    start_load_a();
    repeat ($urandom_range(3, 200)) begin @(posedge clk); #1; end
    #2;
    rst_a_n = 0;
    qa.delete();
    #1;
    check("rnd_rst_flags", 64'({a_valid, a_busy, a_done}), 64'(0));
    check("rnd_rst_addr_data", {a_addr, a_data}, 64'(0));
    @(posedge clk); #1;
    rst_a_n = 1;
    repeat (3) begin @(posedge clk); #1; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
